// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 4
);
  logic [REG_ADDR_W-1:0] id_rn_addr;
  logic [REG_ADDR_W-1:0] id_rm_addr;
  logic                  id_uses_rn;
  logic                  id_uses_rm;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic [REG_ADDR_W-1:0] mem_rd_addr;
  logic [REG_ADDR_W-1:0] wb_rd_addr;
  logic                  ex_reg_write;
  logic                  mem_reg_write;
  logic                  wb_reg_write;
  logic                  ex_mem_read;
  logic                  branch_taken;
  logic                  pc_enable;
  logic                  if_id_enable;
  logic                  if_id_flush;
  logic                  cu_mux_select;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;
  logic [1:0]            ctrl_state;

  modport master (
    output id_rn_addr, id_rm_addr,
    output id_uses_rn, id_uses_rm,
    output ex_rd_addr, mem_rd_addr,
    output wb_rd_addr,
    output ex_reg_write, mem_reg_write,
    output wb_reg_write,
    output ex_mem_read, branch_taken,
    input  pc_enable, if_id_enable,
    input  if_id_flush, cu_mux_select,
    input  fwd_a_sel, fwd_b_sel,
    input  ctrl_state
  );

  modport slave (
    input  id_rn_addr, id_rm_addr,
    input  id_uses_rn, id_uses_rm,
    input  ex_rd_addr, mem_rd_addr,
    input  wb_rd_addr,
    input  ex_reg_write, mem_reg_write,
    input  wb_reg_write,
    input  ex_mem_read, branch_taken,
    output pc_enable, if_id_enable,
    output if_id_flush, cu_mux_select,
    output fwd_a_sel, fwd_b_sel,
    output ctrl_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush FSM and forwarding select.
// Define HAZARD_FORWARDING_EN to enable operand forwarding.
module hazard_ctrl #(
  parameter int                  REG_ADDR_W = 4,
  parameter logic [REG_ADDR_W-1:0] PC_REG   = 4'hF
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;

  logic w_a_ex, w_a_mem, w_a_wb;
  logic w_b_ex, w_b_mem, w_b_wb;
  logic [1:0] w_n_a, w_n_b, w_n;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_hazard;

  logic       w_pc_en;
  logic       w_ifid_en;
  logic       w_flush;
  logic       w_cu_sel;
  logic [1:0] w_fa;
  logic [1:0] w_fb;

  function automatic logic dep(
    input logic                  uses,
    input logic                  wr,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] src
  );
    return uses && wr && (rd == src) &&
           (src != PC_REG);
  endfunction

  function automatic logic [1:0] youngest(
    input logic ex,
    input logic mem,
    input logic wb
  );
    if (ex)       return 2'b01;
    else if (mem) return 2'b10;
    else if (wb)  return 2'b11;
    else          return 2'b00;
  endfunction

  assign w_a_ex  = dep(hz.id_uses_rn,
                       hz.ex_reg_write,
                       hz.ex_rd_addr,
                       hz.id_rn_addr);
  assign w_a_mem = dep(hz.id_uses_rn,
                       hz.mem_reg_write,
                       hz.mem_rd_addr,
                       hz.id_rn_addr);
  assign w_a_wb  = dep(hz.id_uses_rn,
                       hz.wb_reg_write,
                       hz.wb_rd_addr,
                       hz.id_rn_addr);
  assign w_b_ex  = dep(hz.id_uses_rm,
                       hz.ex_reg_write,
                       hz.ex_rd_addr,
                       hz.id_rm_addr);
  assign w_b_mem = dep(hz.id_uses_rm,
                       hz.mem_reg_write,
                       hz.mem_rd_addr,
                       hz.id_rm_addr);
  assign w_b_wb  = dep(hz.id_uses_rm,
                       hz.wb_reg_write,
                       hz.wb_rd_addr,
                       hz.id_rm_addr);

`ifdef HAZARD_FORWARDING_EN
  assign w_fwd_a = youngest(w_a_ex, w_a_mem, w_a_wb);
  assign w_fwd_b = youngest(w_b_ex, w_b_mem, w_b_wb);
  // Only a load in EX cannot be forwarded in time.
  assign w_n_a = (w_a_ex && hz.ex_mem_read) ? 2'd1 : 2'd0;
  assign w_n_b = (w_b_ex && hz.ex_mem_read) ? 2'd1 : 2'd0;
`else
  logic [1:0] w_yng_a, w_yng_b;
  logic       w_unused;

  assign w_unused = hz.ex_mem_read;
  assign w_fwd_a  = 2'b00;
  assign w_fwd_b  = 2'b00;
  assign w_yng_a  = youngest(w_a_ex, w_a_mem, w_a_wb);
  assign w_yng_b  = youngest(w_b_ex, w_b_mem, w_b_wb);
  // EX->3, MEM->2, WB->1 cycles until the value reaches the regfile.
  assign w_n_a = (w_yng_a == 2'b00) ? 2'd0
                                    : 2'd0 - w_yng_a;
  assign w_n_b = (w_yng_b == 2'b00) ? 2'd0
                                    : 2'd0 - w_yng_b;
`endif

  assign w_n      = (w_n_a > w_n_b) ? w_n_a : w_n_b;
  assign w_hazard = (w_n != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_en     = 1'b1;
    w_ifid_en   = 1'b1;
    w_flush     = 1'b0;
    w_cu_sel    = 1'b0;
    w_fa        = 2'b00;
    w_fb        = 2'b00;
    unique case (r_state)
      RUN: begin
        w_fa = w_fwd_a;
        w_fb = w_fwd_b;
        if (w_hazard) begin
          w_pc_en     = 1'b0;
          w_ifid_en   = 1'b0;
          w_cu_sel    = 1'b1;
          w_cnt_nxt   = w_n - 2'd1;
          w_state_nxt = (w_n > 2'd1) ? STALL : RUN;
        end else if (hz.branch_taken) begin
          w_flush     = 1'b1;
          w_state_nxt = FLUSH;
        end
      end
      STALL: begin
        w_pc_en   = 1'b0;
        w_ifid_en = 1'b0;
        w_cu_sel  = 1'b1;
        // Leave on the edge that brings the counter to zero.
        if (r_cnt <= 2'd1) begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      FLUSH: begin
        w_cu_sel    = 1'b1;
        w_state_nxt = RUN;
      end
      default: begin
        w_cnt_nxt   = 2'd0;
        w_state_nxt = RUN;
      end
    endcase
    if (!rst_n) begin
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
      w_flush   = 1'b1;
      w_cu_sel  = 1'b1;
      w_fa      = 2'b00;
      w_fb      = 2'b00;
    end
  end

  assign hz.pc_enable     = w_pc_en;
  assign hz.if_id_enable  = w_ifid_en;
  assign hz.if_id_flush   = w_flush;
  assign hz.cu_mux_select = w_cu_sel;
  assign hz.fwd_a_sel     = w_fa;
  assign hz.fwd_b_sel     = w_fb;
  assign hz.ctrl_state    = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a scoreboard queue.
// Expectations follow HAZARD_FORWARDING_EN when defined.
module tb_hazard_ctrl;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b0;

  hazard_ctrl_if #(.REG_ADDR_W(4)) hz ();

  hazard_ctrl #(
    .REG_ADDR_W(4),
    .PC_REG    (4'hF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  localparam logic [3:0] C_RUN = 4'b1100;
  localparam logic [3:0] C_STL = 4'b0001;
  localparam logic [3:0] C_BR  = 4'b1110;
  localparam logic [3:0] C_FL  = 4'b1101;
  localparam logic [3:0] C_RST = 4'b0011;

  function automatic logic [9:0] ev(
    input logic [3:0] c,
    input logic [1:0] fa,
    input logic [1:0] fb,
    input logic [1:0] st
  );
    return {c, fa, fb, st};
  endfunction

  task automatic push(input string t,
                      input logic [9:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [9:0] obs;
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty obs=none exp=entry");
      return;
    end
    e   = sb.pop_front();
    obs = {hz.pc_enable, hz.if_id_enable,
           hz.if_id_flush, hz.cu_mux_select,
           hz.fwd_a_sel, hz.fwd_b_sel,
           hz.ctrl_state};
    assert (obs === e.v) passed++;
    else $error("FAIL %s obs=%b exp=%b",
                e.tag, obs, e.v);
  endtask

  task automatic cyc(input string t,
                     input logic [9:0] v);
    push(t, v);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hz.id_rn_addr    = '0;
    hz.id_rm_addr    = '0;
    hz.id_uses_rn    = 1'b0;
    hz.id_uses_rm    = 1'b0;
    hz.ex_rd_addr    = '0;
    hz.mem_rd_addr   = '0;
    hz.wb_rd_addr    = '0;
    hz.ex_reg_write  = 1'b0;
    hz.mem_reg_write = 1'b0;
    hz.wb_reg_write  = 1'b0;
    hz.ex_mem_read   = 1'b0;
    hz.branch_taken  = 1'b0;
  endtask

  task automatic src(input logic [3:0] rn,
                     input logic       urn,
                     input logic [3:0] rm,
                     input logic       urm);
    hz.id_rn_addr = rn;
    hz.id_uses_rn = urn;
    hz.id_rm_addr = rm;
    hz.id_uses_rm = urm;
  endtask

  task automatic ex(input logic [3:0] rd,
                    input logic wr,
                    input logic ld);
    hz.ex_rd_addr   = rd;
    hz.ex_reg_write = wr;
    hz.ex_mem_read  = ld;
  endtask

  task automatic mem(input logic [3:0] rd,
                     input logic wr);
    hz.mem_rd_addr   = rd;
    hz.mem_reg_write = wr;
  endtask

  task automatic wb(input logic [3:0] rd,
                    input logic wr);
    hz.wb_rd_addr   = rd;
    hz.wb_reg_write = wr;
  endtask

  initial begin
    clr();
    ex(4'd5, 1'b1, 1'b1);
    src(4'd5, 1'b1, 4'd5, 1'b1);
    #20;
    push("rst_noclk", ev(C_RST, 2'b00, 2'b00, 2'b00));
    check_out();

    clk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    push("rst_clk", ev(C_RST, 2'b00, 2'b00, 2'b00));
    check_out();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    cyc("idle", ev(C_RUN, 2'b00, 2'b00, 2'b00));
    cyc("idle2", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    ex(4'hF, 1'b1, 1'b0);
    src(4'hF, 1'b1, 4'hF, 1'b1);
    cyc("pc_excl", ev(C_RUN, 2'b00, 2'b00, 2'b00));
    ex(4'd5, 1'b1, 1'b0);
    src(4'd5, 1'b0, 4'd5, 1'b0);
    cyc("no_uses", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    clr();
    hz.branch_taken = 1'b1;
    cyc("br_run", ev(C_BR, 2'b00, 2'b00, 2'b00));
    cyc("br_flush", ev(C_FL, 2'b00, 2'b00, 2'b10));
    hz.branch_taken = 1'b0;
    cyc("br_after", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    hz.branch_taken = 1'b1;
    cyc("rf_br", ev(C_BR, 2'b00, 2'b00, 2'b00));
    push("rf_fl", ev(C_FL, 2'b00, 2'b00, 2'b10));
    @(negedge clk);
    check_out();
    rst_n = 1'b0;
    #1;
    push("rf_rst", ev(C_RST, 2'b00, 2'b00, 2'b00));
    check_out();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    cyc("rf_run", ev(C_RUN, 2'b00, 2'b00, 2'b00));

`ifdef HAZARD_FORWARDING_EN
    ex(4'd3, 1'b1, 1'b1);
    src(4'd3, 1'b1, 4'd0, 1'b0);
    cyc("ld_stall", ev(C_STL, 2'b01, 2'b00, 2'b00));
    clr();
    mem(4'd3, 1'b1);
    src(4'd3, 1'b1, 4'd0, 1'b0);
    cyc("ld_fwd", ev(C_RUN, 2'b10, 2'b00, 2'b00));

    clr();
    ex(4'd2, 1'b1, 1'b0);
    src(4'd0, 1'b0, 4'd2, 1'b1);
    cyc("alu_fwd", ev(C_RUN, 2'b00, 2'b01, 2'b00));
    ex(4'hF, 1'b1, 1'b0);
    src(4'd0, 1'b0, 4'hF, 1'b1);
    cyc("alu_pc", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    ex(4'd1, 1'b1, 1'b0);
    mem(4'd1, 1'b1);
    wb(4'd1, 1'b1);
    src(4'd1, 1'b1, 4'd1, 1'b1);
    cyc("pri_ex", ev(C_RUN, 2'b01, 2'b01, 2'b00));
    ex(4'd1, 1'b0, 1'b0);
    cyc("pri_mem", ev(C_RUN, 2'b10, 2'b10, 2'b00));
    mem(4'd1, 1'b0);
    cyc("pri_wb", ev(C_RUN, 2'b11, 2'b11, 2'b00));

    clr();
    ex(4'd3, 1'b1, 1'b1);
    src(4'd3, 1'b1, 4'd3, 1'b1);
    cyc("ld_both", ev(C_STL, 2'b01, 2'b01, 2'b00));
    src(4'd4, 1'b1, 4'd0, 1'b0);
    cyc("ld_nomatch", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    clr();
    ex(4'd2, 1'b1, 1'b0);
    src(4'd2, 1'b1, 4'd0, 1'b0);
    hz.branch_taken = 1'b1;
    cyc("brf_run", ev(C_BR, 2'b01, 2'b00, 2'b00));
    cyc("brf_fl", ev(C_FL, 2'b00, 2'b00, 2'b10));
    clr();
    cyc("brf_after", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    ex(4'd3, 1'b1, 1'b1);
    src(4'd3, 1'b1, 4'd0, 1'b0);
    hz.branch_taken = 1'b1;
    cyc("brh_stall", ev(C_STL, 2'b01, 2'b00, 2'b00));
    ex(4'd0, 1'b0, 1'b0);
    mem(4'd3, 1'b1);
    cyc("brh_br", ev(C_BR, 2'b10, 2'b00, 2'b00));
    cyc("brh_fl", ev(C_FL, 2'b00, 2'b00, 2'b10));
    clr();
    cyc("brh_run", ev(C_RUN, 2'b00, 2'b00, 2'b00));
`else
    ex(4'd5, 1'b1, 1'b0);
    src(4'd5, 1'b1, 4'd0, 1'b0);
    cyc("ex_s1", ev(C_STL, 2'b00, 2'b00, 2'b00));
    cyc("ex_s2", ev(C_STL, 2'b00, 2'b00, 2'b01));
    cyc("ex_s3", ev(C_STL, 2'b00, 2'b00, 2'b01));
    clr();
    cyc("ex_run", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    mem(4'd7, 1'b1);
    src(4'd0, 1'b0, 4'd7, 1'b1);
    cyc("mem_s1", ev(C_STL, 2'b00, 2'b00, 2'b00));
    cyc("mem_s2", ev(C_STL, 2'b00, 2'b00, 2'b01));
    clr();
    cyc("mem_run", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    wb(4'd9, 1'b1);
    src(4'd9, 1'b1, 4'd0, 1'b0);
    cyc("wb_s1", ev(C_STL, 2'b00, 2'b00, 2'b00));
    clr();
    cyc("wb_run", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    ex(4'd4, 1'b1, 1'b0);
    wb(4'd4, 1'b1);
    src(4'd4, 1'b1, 4'd0, 1'b0);
    cyc("yng_s1", ev(C_STL, 2'b00, 2'b00, 2'b00));
    cyc("yng_s2", ev(C_STL, 2'b00, 2'b00, 2'b01));
    cyc("yng_s3", ev(C_STL, 2'b00, 2'b00, 2'b01));
    clr();
    cyc("yng_run", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    wb(4'd6, 1'b1);
    mem(4'd8, 1'b1);
    src(4'd6, 1'b1, 4'd8, 1'b1);
    cyc("max_s1", ev(C_STL, 2'b00, 2'b00, 2'b00));
    cyc("max_s2", ev(C_STL, 2'b00, 2'b00, 2'b01));
    clr();
    cyc("max_run", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    ex(4'd5, 1'b0, 1'b0);
    src(4'd5, 1'b1, 4'd5, 1'b1);
    cyc("no_wr", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    ex(4'd5, 1'b1, 1'b0);
    src(4'd5, 1'b1, 4'd0, 1'b0);
    hz.branch_taken = 1'b1;
    cyc("brh_s1", ev(C_STL, 2'b00, 2'b00, 2'b00));
    cyc("brh_s2", ev(C_STL, 2'b00, 2'b00, 2'b01));
    cyc("brh_s3", ev(C_STL, 2'b00, 2'b00, 2'b01));
    clr();
    hz.branch_taken = 1'b1;
    cyc("brh_br", ev(C_BR, 2'b00, 2'b00, 2'b00));
    cyc("brh_fl", ev(C_FL, 2'b00, 2'b00, 2'b10));
    hz.branch_taken = 1'b0;
    cyc("brh_run", ev(C_RUN, 2'b00, 2'b00, 2'b00));

    ex(4'd5, 1'b1, 1'b0);
    src(4'd5, 1'b1, 4'd0, 1'b0);
    cyc("rs_s1", ev(C_STL, 2'b00, 2'b00, 2'b00));
    push("rs_s2", ev(C_STL, 2'b00, 2'b00, 2'b01));
    @(negedge clk);
    check_out();
    rst_n = 1'b0;
    #1;
    push("rs_rst", ev(C_RST, 2'b00, 2'b00, 2'b00));
    check_out();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    cyc("rs_run1", ev(C_RUN, 2'b00, 2'b00, 2'b00));
    cyc("rs_run2", ev(C_RUN, 2'b00, 2'b00, 2'b00));
`endif

    checks++;
    assert (sb.size() == 0) passed++;
    else $error("FAIL sb_left obs=%0d exp=0",
                sb.size());

    $display("%0d/%0d checks passed",
             passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: REG_ADDR_W, default 4, register address width (R0-R15).
REQ-002 Parameter: PC_REG, default 4'hF, register address excluded from hazard checks.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; port list follows.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 id_rn_addr, id_rm_addr  in  REG_ADDR_W  source registers of the instruction in ID.
REQ-007 id_uses_rn, id_uses_rm  in  1  source operand actually read.
REQ-008 ex_rd_addr, mem_rd_addr, wb_rd_addr  in  REG_ADDR_W  destination in EX/MEM/WB.
REQ-009 ex_reg_write, mem_reg_write, wb_reg_write  in  1  stage will write its rd.
REQ-010 ex_mem_read  in  1  EX instruction is a load.
REQ-011 branch_taken  in  1  branch resolved taken in ID this cycle.
REQ-012 pc_enable  out  1  PC register load enable.
REQ-013 if_id_enable  out  1  IF/ID pipeline register load enable.
REQ-014 if_id_flush  out  1  IF/ID register cleared to NOP next edge.
REQ-015 cu_mux_select  out  1  1 = control-unit mux inserts bubble (all control signals zero) into ID/EX.
REQ-016 fwd_a_sel, fwd_b_sel  out  2  operand source: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-017 ctrl_state  out  2  FSM state for debug: 00 RUN, 01 STALL, 10 FLUSH.

Function
REQ-018 Dependency: source s matches stage X when id_uses_s=1, X_reg_write=1, X_rd_addr==s, and s!=PC_REG.
REQ-019 FSM states RUN, STALL, FLUSH; 2-bit down-counter stall_cnt.
REQ-020 RUN, no hazard, no branch: pc_enable=1, if_id_enable=1, if_id_flush=0, cu_mux_select=0; remain RUN.
REQ-021 RUN, hazard with required stall count N>0: outputs in that same cycle pc_enable=0, if_id_enable=0, cu_mux_select=1; stall_cnt<=N-1; next state STALL if N>1, else RUN.
REQ-022 STALL: outputs as REQ-021; stall_cnt decrements each edge; transition to RUN on the edge where stall_cnt==0.
REQ-023 RUN, branch_taken=1 and no hazard: if_id_flush=1, pc_enable=1, if_id_enable=1, cu_mux_select=0; next state FLUSH.
REQ-024 FLUSH lasts exactly one cycle: if_id_flush=0, cu_mux_select=1, pc_enable=1, if_id_enable=1; next state RUN.
REQ-025 Simultaneous hazard and branch_taken in RUN: hazard wins; branch_taken re-evaluated after stall.
REQ-026 branch_taken SHALL be ignored in STALL and FLUSH.
REQ-027 When both operands hazard, N = maximum of the two per-operand counts.
REQ-028 ctrl_state SHALL equal the registered state at all times.

Reset
REQ-029 While rst_n=0: state=RUN, stall_cnt=0, pc_enable=0, if_id_enable=0, if_id_flush=1, cu_mux_select=1, fwd_a_sel=fwd_b_sel=00, ctrl_state=00, independent of clk.
REQ-030 Reset asserted mid-STALL or mid-FLUSH SHALL abort the sequence immediately; first edge after release evaluates RUN rules.

Configuration
REQ-031 Macro HAZARD_FORWARDING_EN selects operand forwarding.
REQ-032 Defined: fwd_*_sel picks youngest matching stage (EX over MEM over WB), 00 if none; N=1 only for EX match with ex_mem_read=1, else N=0; fwd_*_sel valid only in RUN, forced 00 in STALL/FLUSH.
REQ-033 Undefined: fwd_*_sel constant 00; N=3 for EX match, 2 for MEM match, 1 for WB match, youngest match governs per operand.

Verification
REQ-034 rst_n=0 with clk stopped -> pc_enable=0, cu_mux_select=1, if_id_flush=1; release -> RUN, pc_enable=1 next cycle.
REQ-035 FORWARDING_EN, EX load rd=R3, ID rn=R3 -> one cycle cu_mux_select=1, pc_enable=0; then fwd_a_sel=10 with load in MEM.
REQ-036 FORWARDING_EN, EX ALU rd=R2, ID rm=R2 -> no stall, fwd_b_sel=01; rd=R15 match -> fwd_b_sel=00.
REQ-037 No FORWARDING_EN, EX rd=R5, ID rn=R5 -> exactly 3 stall cycles, ctrl_state 01 for 2 cycles, then RUN.
REQ-038 branch_taken=1 in RUN -> if_id_flush=1 one cycle, then cu_mux_select=1 one cycle (FLUSH), then RUN; branch_taken with hazard -> stall first, no flush.
REQ-039 rst_n pulsed low during cycle 2 of a 3-cycle stall -> outputs take reset values immediately; RUN after release, no residual stall.
